// File: rtl/vga_pixel_fetch.sv
// Raster tracker with a two-pixel lookahead fetch from a 1-bpp frame memory and a two-colour palette.
// Optional build macro PATTERN_EN adds pattern_sel, which swaps memory fetch for eight colour bars.
module vga_pixel_fetch #(
  parameter int unsigned H_SYNC_PULSE   = 96,
  parameter int unsigned H_BACK_PORCH   = 48,
  parameter int unsigned H_ACTIVE_TIME  = 640,
  parameter int unsigned H_LINE_PERIOD  = 800,
  parameter int unsigned V_SYNC_PULSE   = 2,
  parameter int unsigned V_BACK_PORCH   = 33,
  parameter int unsigned V_ACTIVE_TIME  = 480,
  parameter int unsigned V_FRAME_PERIOD = 525,
  parameter logic [11:0] FG_COLOR       = 12'hFFF,
  parameter logic [11:0] BG_COLOR       = 12'h000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        sof,
`ifdef PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        rd_en,
  output logic [18:0] rd_addr,
  input  logic        rd_data,
  output logic [11:0] component,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned HW = $clog2(H_LINE_PERIOD + 1);
  localparam int unsigned VW = $clog2(V_FRAME_PERIOD + 1);
  localparam int unsigned AW = 19;

  localparam logic [HW-1:0] H_LAST  = HW'(H_LINE_PERIOD - 1);
  localparam logic [HW-1:0] H_START = HW'(H_SYNC_PULSE + H_BACK_PORCH);
  localparam logic [HW-1:0] H_END   = HW'(H_SYNC_PULSE + H_BACK_PORCH + H_ACTIVE_TIME);
  localparam logic [VW-1:0] V_LAST  = VW'(V_FRAME_PERIOD - 1);
  localparam logic [VW-1:0] V_START = VW'(V_SYNC_PULSE + V_BACK_PORCH);
  localparam logic [VW-1:0] V_END   = VW'(V_SYNC_PULSE + V_BACK_PORCH + V_ACTIVE_TIME);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h, n1_h, n2_h;
  logic [VW-1:0] v, n1_v, n2_v;
  logic          bit_reg, rd_valid;
  logic          start_c, resync_c, step_c, at_end_c;
  logic          fetch_c, bit_now_c, pattern_c;
  logic [11:0]   pixel_c, bar_rgb_c;

  function automatic logic is_active(input logic [HW-1:0] hh, input logic [VW-1:0] vv);
    return (hh >= H_START) && (hh < H_END) && (vv >= V_START) && (vv < V_END);
  endfunction

  function automatic logic [AW-1:0] pix_addr(input logic [HW-1:0] hh, input logic [VW-1:0] vv);
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    x = AW'(hh - H_START);
    y = AW'(vv - V_START);
    return x + y * AW'(H_ACTIVE_TIME);
  endfunction

  // Raster one and two pixels ahead, with line and frame wrap
  assign n1_h = (h == H_LAST) ? '0 : h + HW'(1);
  assign n1_v = (h != H_LAST) ? v : ((v == V_LAST) ? '0 : v + VW'(1));
  assign n2_h = (n1_h == H_LAST) ? '0 : n1_h + HW'(1);
  assign n2_v = (n1_h != H_LAST) ? n1_v : ((n1_v == V_LAST) ? '0 : n1_v + VW'(1));
  assign at_end_c = (h == H_LAST) && (v == V_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pix_en && sof) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // A sof landing on the natural end of frame is just the normal wrap
  always_comb begin
    start_c  = 1'b0;
    resync_c = 1'b0;
    step_c   = 1'b0;
    case (state)
      IDLE: start_c = pix_en && sof;
      RUN: begin
        resync_c = pix_en && sof && !at_end_c;
        step_c   = pix_en && !resync_c;
      end
      default: ;
    endcase
  end

`ifdef PATTERN_EN
  localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE_TIME / 8);
  logic [2:0] bar_idx_c;

  assign pattern_c = pattern_sel;
  assign bar_idx_c = 3'((n1_h - H_START) / BAR_W);

  always_comb begin
    bar_rgb_c = 12'h000;
    case (bar_idx_c)
      3'd0: bar_rgb_c = 12'h000;
      3'd1: bar_rgb_c = 12'hF00;
      3'd2: bar_rgb_c = 12'h0F0;
      3'd3: bar_rgb_c = 12'h00F;
      3'd4: bar_rgb_c = 12'hFF0;
      3'd5: bar_rgb_c = 12'h0FF;
      3'd6: bar_rgb_c = 12'hF0F;
      3'd7: bar_rgb_c = 12'hFFF;
      default: bar_rgb_c = 12'h000;
    endcase
  end
`else
  assign pattern_c = 1'b0;
  assign bar_rgb_c = 12'h000;
`endif

  assign fetch_c = step_c && !pattern_c && is_active(n2_h, n2_v);

  // With pix_en two clocks apart the read data lands on the same edge that consumes it
  assign bit_now_c = rd_valid ? rd_data : bit_reg;

  always_comb begin
    pixel_c = 12'h000;
    if (is_active(n1_h, n1_v))
      pixel_c = pattern_c ? bar_rgb_c : (bit_now_c ? FG_COLOR : BG_COLOR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h         <= '0;
      v         <= '0;
      bit_reg   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      component <= 12'h000;
      frame_cnt <= 8'd0;
    end else begin
      rd_en    <= fetch_c;
      rd_valid <= rd_en && !resync_c;
      if (fetch_c) rd_addr <= pix_addr(n2_h, n2_v);

      if (start_c || resync_c) begin
        h         <= '0;
        v         <= '0;
        component <= 12'h000;
        bit_reg   <= 1'b0;
      end else if (step_c) begin
        h         <= n1_h;
        v         <= n1_v;
        component <= pixel_c;
        if (!fetch_c)     bit_reg <= 1'b0;
        else if (rd_valid) bit_reg <= rd_data;
        if (at_end_c) frame_cnt <= frame_cnt + 8'd1;
      end else if (rd_valid) begin
        bit_reg <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch on a reduced raster (20x8 total, 8x4 active) with a frame-memory model.
module tb_vga_pixel_fetch;

  localparam int HS = 4, HBP = 4, HACT = 8, HLINE = 20;
  localparam int VS = 1, VBP = 2, VACT = 4, VFRAME = 8;
  localparam int H0 = HS + HBP, H1 = H0 + HACT;
  localparam int V0 = VS + VBP, V1 = V0 + VACT;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pix_en = 1'b0;
  logic        sof = 1'b0;
  logic        rd_data = 1'b0;
  logic        rd_en;
  logic [18:0] rd_addr;
  logic [11:0] component;
  logic [7:0]  frame_cnt;

  int checks = 0, errors = 0;
  int mem_mode = 0;
  int mh = 0, mv = 0, mrun = 0, mframe = 0;
  int reads = 0, first_addr = -1, last_addr = -1;

  vga_pixel_fetch #(
    .H_SYNC_PULSE(HS), .H_BACK_PORCH(HBP), .H_ACTIVE_TIME(HACT), .H_LINE_PERIOD(HLINE),
    .V_SYNC_PULSE(VS), .V_BACK_PORCH(VBP), .V_ACTIVE_TIME(VACT), .V_FRAME_PERIOD(VFRAME),
    .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pix_en(pix_en),
    .sof(sof),
`ifdef PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .component(component),
    .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic mem_bit(input int a);
    if (mem_mode == 0) return 1'b1;
    if (mem_mode == 1) return a[0];
    return 1'b0;
  endfunction

  // Memory: data valid the clock after the request
  always @(posedge clock) rd_data <= rd_en ? mem_bit(int'(rd_addr)) : 1'b0;

  always @(posedge clock) begin
    if (rd_en === 1'b1) begin
      if (reads == 0) first_addr = int'(rd_addr);
      last_addr = int'(rd_addr);
      reads++;
    end
  end

  function automatic logic m_active(input int h, input int v);
    return (h >= H0) && (h < H1) && (v >= V0) && (v < V1);
  endfunction
  function automatic int m_addr(input int h, input int v);
    return (h - H0) + HACT * (v - V0);
  endfunction
  function automatic int nxt_h(input int h);
    return (h == HLINE - 1) ? 0 : h + 1;
  endfunction
  function automatic int nxt_v(input int h, input int v);
    if (h != HLINE - 1) return v;
    return (v == VFRAME - 1) ? 0 : v + 1;
  endfunction

  // One pixel strobe, then check outputs against the raster model
  task automatic step(input logic s, input int gap);
    int fh, fv;
    logic [11:0] exp_c;
    logic exp_rd;
    fh = 0; fv = 0; exp_c = 12'h000; exp_rd = 1'b0;
    @(negedge clock);
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("FAIL rd_en_width: got %b expected 0", rd_en); end
    pix_en = 1'b1; sof = s;
    @(negedge clock);
    pix_en = 1'b0; sof = 1'b0;
    if (mrun == 0) begin
      if (s) begin mrun = 1; mh = 0; mv = 0; end
    end else if (s && !(mh == HLINE - 1 && mv == VFRAME - 1)) begin
      mh = 0; mv = 0;
    end else begin
      if (mh == HLINE - 1 && mv == VFRAME - 1) mframe = (mframe + 1) % 256;
      fv = nxt_v(mh, mv); mh = nxt_h(mh); mv = fv;
      exp_c = m_active(mh, mv) ? (mem_bit(m_addr(mh, mv)) ? 12'hFFF : 12'h000) : 12'h000;
      fh = nxt_h(mh); fv = nxt_v(mh, mv);
      exp_rd = m_active(fh, fv);
    end
    checks++;
    if (component !== exp_c) begin
      errors++; $display("FAIL component at (%0d,%0d): got %h expected %h", mh, mv, component, exp_c);
    end
    checks++;
    if (rd_en !== exp_rd) begin
      errors++; $display("FAIL rd_en at (%0d,%0d): got %b expected %b", mh, mv, rd_en, exp_rd);
    end
    if (exp_rd) begin
      checks++;
      if (rd_addr !== 19'(m_addr(fh, fv))) begin
        errors++; $display("FAIL rd_addr at (%0d,%0d): got %0d expected %0d", mh, mv, rd_addr, m_addr(fh, fv));
      end
    end
    checks++;
    if (frame_cnt !== 8'(mframe)) begin
      errors++; $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt, mframe);
    end
    repeat (gap) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (component !== 12'h000) begin errors++; $display("FAIL reset_component: got %h expected 000", component); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    checks++; if (rd_addr !== 19'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    reset = 1'b1;
    mrun = 0; mframe = 0;
  endtask

  task automatic test_idle;
    mem_mode = 0;
    reads = 0;
    repeat (1000) step(1'b0, 0);
    checks++; if (reads != 0) begin errors++; $display("FAIL idle_reads: got %0d expected 0", reads); end
  endtask

  task automatic test_first_fetch;
    mem_mode = 0;
    step(1'b1, 0);
    for (int i = 0; i < HLINE * VFRAME && !(mh == H0 - 2 && mv == V0); i++) step(1'b0, 0);
    step(1'b0, 0);
    checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL first_rd_en: got %b expected 1", rd_en); end
    checks++; if (rd_addr !== 19'd0) begin errors++; $display("FAIL first_rd_addr: got %0d expected 0", rd_addr); end
    checks++; if (component !== 12'h000) begin errors++; $display("FAIL first_pre_component: got %h expected 000", component); end
    step(1'b0, 0);
    checks++; if (component !== 12'hFFF) begin errors++; $display("FAIL first_component: got %h expected fff", component); end
  endtask

  task automatic test_full_frame;
    mem_mode = 1;
    step(1'b1, 0);
    reads = 0;
    for (int i = 0; i < HLINE * VFRAME; i++) begin
      step(1'b0, (i % 5 == 0) ? 1 : 0);
      if (mh == H0 && mv == V0) begin
        checks++; if (component !== 12'h000) begin errors++; $display("FAIL alt_x0: got %h expected 000", component); end
      end
      if (mh == H0 + 1 && mv == V0) begin
        checks++; if (component !== 12'hFFF) begin errors++; $display("FAIL alt_x1: got %h expected fff", component); end
      end
    end
    checks++; if (reads != HACT * VACT) begin errors++; $display("FAIL frame_reads: got %0d expected %0d", reads, HACT * VACT); end
    checks++; if (first_addr != 0) begin errors++; $display("FAIL first_addr: got %0d expected 0", first_addr); end
    checks++; if (last_addr != 31) begin errors++; $display("FAIL last_addr: got %0d expected 31", last_addr); end
  endtask

  task automatic test_three_frames;
    mem_mode = 0;
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    mrun = 0; mframe = 0;
    step(1'b1, 0);
    for (int i = 0; i < 3 * HLINE * VFRAME; i++) begin
      step(1'b0, (i % 3 == 0) ? 1 : 0);
      if ((mh == H1 && mv == V0) || (mh == H0 && mv == V1)) begin
        checks++; if (component !== 12'h000) begin errors++; $display("FAIL blank_edge (%0d,%0d): got %h expected 000", mh, mv, component); end
      end
    end
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL three_frames: got %0d expected 3", frame_cnt); end
  endtask

  task automatic test_sof_mid;
    mem_mode = 0;
    for (int i = 0; i < HLINE * VFRAME && !(mh == 10 && mv == 4); i++) step(1'b0, 0);
    checks++; if (component !== 12'hFFF) begin errors++; $display("FAIL pre_sof_component: got %h expected fff", component); end
    step(1'b1, 0);
    checks++; if (component !== 12'h000) begin errors++; $display("FAIL sof_component: got %h expected 000", component); end
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL sof_frame_cnt: got %0d expected 3", frame_cnt); end
    for (int i = 0; i < HLINE * VFRAME && !(mh == HLINE - 1 && mv == VFRAME - 1); i++) step(1'b0, 0);
    step(1'b1, 0);
    checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL wrap_sof_frame_cnt: got %0d expected 4", frame_cnt); end
    repeat (HLINE * 4) step(1'b0, 0);
  endtask

  task automatic test_reset_mid;
    mem_mode = 0;
    for (int i = 0; i < HLINE * VFRAME && !(mh == H0 + 2 && mv == V0 + 1); i++) step(1'b0, 0);
    checks++; if (component !== 12'hFFF) begin errors++; $display("FAIL mid_component: got %h expected fff", component); end
    #1 reset = 1'b0;
    #1;
    checks++; if (component !== 12'h000) begin errors++; $display("FAIL async_component: got %h expected 000", component); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL async_rd_en: got %b expected 0", rd_en); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL async_frame_cnt: got %0d expected 0", frame_cnt); end
    @(negedge clock); reset = 1'b1;
    mrun = 0; mframe = 0;
    repeat (40) step(1'b0, 0);
    step(1'b1, 0);
    for (int i = 0; i < HLINE * VFRAME && !(mh == H0 && mv == V0); i++) step(1'b0, 0);
    checks++; if (component !== 12'hFFF) begin errors++; $display("FAIL restart_component: got %h expected fff", component); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_first_fetch();
    test_full_frame();
    test_three_frames();
    test_sof_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Feeds the VGA output stage with one 12-bit RGB component per pixel period, replacing the flat 307200-bit bitmap bus with a 1-bit-per-pixel frame-memory read port.
- Tracks its own raster position, locked to the display timing by a start-of-frame pulse.
- Prefetches each bitmap bit two pixels ahead and maps it through a two-colour palette.
- Blanks to 0 outside the active window.

Parameters:
H_SYNC_PULSE, 96, horizontal sync width in pixels
H_BACK_PORCH, 48, horizontal back porch
H_ACTIVE_TIME, 640, active pixels per line
H_LINE_PERIOD, 800, pixels per line
V_SYNC_PULSE, 2, vertical sync lines
V_BACK_PORCH, 33, vertical back porch
V_ACTIVE_TIME, 480, active lines
V_FRAME_PERIOD, 525, lines per frame
FG_COLOR, 12'hFFF, RGB for bitmap bit 1
BG_COLOR, 12'h000, RGB for bitmap bit 0

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low
pix_en  in  1  one-clock pixel strobe (25 MHz rate); at least one idle clock between pulses
sof  in  1  start-of-frame; sampled only when pix_en=1; forces raster to (h=0,v=0)
rd_en  out  1  frame-memory read request, one clock wide
rd_addr  out  19  bitmap address = x + 640*y, range 0..307199
rd_data  in  1  bitmap bit, valid exactly 1 clock after rd_en
component  out  12  RGB {r[11:8],g[7:4],b[3:0]} for the current raster position
frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset: state=IDLE, h=0, v=0, bit_reg=0, component=0, rd_en=0, rd_addr=0, frame_cnt=0.
- FSM states:
  - IDLE: counters hold; no reads; component=0. On pix_en&sof go to RUN and set h=0,v=0.
  - RUN: on each pix_en, h increments; at h=H_LINE_PERIOD-1, h wraps to 0 and v increments; at v=V_FRAME_PERIOD-1 with h wrap, v wraps to 0 and frame_cnt increments.
- Active window: 144<=h<784 and 35<=v<515. Then x=h-144, y=v-35.
- Lookahead:
  - On a pix_en cycle with the raster at P, the block computes P+2 (modulo line and frame wrap).
  - If P+2 is active: rd_en=1 and rd_addr=addr(P+2) in the next clock.
  - Otherwise rd_en stays 0 and bit_reg is forced to 0.
- Capture: bit_reg <= rd_data on the clock after rd_en.
- Output update, on each pix_en edge, when the raster moves P -> P+1:
  - component <= (P+1 active) ? (bit_reg ? FG_COLOR : BG_COLOR) : 12'h000.
  - bit_reg holds pixel P+1 at that point.
- Net latency: address for pixel N issues 2 pixel periods before component shows N; component is registered and stable for a full pixel period.
- sof while in RUN:
  - Resync to (0,0).
  - Clear bit_reg and component.
  - Drop any in-flight read result.
  - frame_cnt is not incremented.
- sof coinciding with natural wrap to (0,0): no effect beyond the normal wrap, and frame_cnt increments once.
- Reset asserted mid-frame: all outputs return to reset values immediately; the block re-enters IDLE and waits for sof.
- Arithmetic: rd_addr is computed as y*640 = (y<<9)+(y<<7), 19-bit, with no overflow for valid x,y.

Optional Feature:
PATTERN_EN:
- When defined, adds input pattern_sel (1 bit).
- While pattern_sel=1:
  - No reads are issued (rd_en=0).
  - Active pixels show 8 vertical colour bars, index x/80, colours in order 000,F00,0F0,00F,FF0,0FF,F0F,FFF.
  - Blanking is unchanged.
- pattern_sel changes take effect on the next pix_en.
- When undefined: the port is absent and the block always fetches from memory.

Test Plan:
1. Reset, then pix_en every 2nd clock with no sof -> state stays IDLE; rd_en never asserts; component=0 for 2000 clocks.
2. sof, then run to raster (142,35) -> rd_en=1 with rd_addr=0 one clock later; with rd_data=1, component=FFF exactly when the raster reaches (144,35).
3. Full frame with memory model returning bit = addr[0] -> active pixels alternate FFF/000 starting at x=0 with FFF only if addr 0 is odd; first addr 0, last addr 307199; 307200 reads per frame; no reads in blanking.
4. Run 3 frames -> frame_cnt=3; lines 515..524 and h>=784 give component=0.
5. sof at raster (400,200) mid-frame -> next pix_en raster=(0,0); component=0; a read in flight that clock is discarded; frame_cnt is unchanged.
6. Reset pulse mid-active-line -> component=0, rd_en=0 asynchronously; block waits in IDLE until the next sof.
